wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//   Drives the single write port (we/waddr/wdata) of the 32x32 register file. Merges two result
//   sources: the in-order ALU pipeline (port A, no backpressure) and a long-latency unit such as
//   the divider or load unit (port B, valid/ready). Port B results wait in a small queue.
//   Reports pending queued writes to ID so ID stalls on RAW hazards the regfile bypass cannot see.
// PARAMETERS
//   DATA_W     32  register data width (`RegBus)
//   ADDR_W     5   register address width (`RegAddrBus)
//   QDEPTH     2   port-B pending queue entries (power of 2, >=2)
//   STARVE_MAX 4   consecutive cycles port A may block a non-empty queue before stall_req
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   a_valid    in   1       port A result valid; always accepted
//   a_waddr    in   ADDR_W  port A destination register
//   a_wdata    in   DATA_W  port A result
//   b_valid    in   1       port B result valid
//   b_ready    out  1       port B may push this cycle
//   b_waddr    in   ADDR_W  port B destination register
//   b_wdata    in   DATA_W  port B result
//   rq1_addr   in   ADDR_W  ID read-port-1 address
//   rq2_addr   in   ADDR_W  ID read-port-2 address
//   rq1_pend   out  1       queued write to rq1_addr pending (comb.)
//   rq2_pend   out  1       queued write to rq2_addr pending (comb.)
//   stall_req  out  1       registered; request pipeline to hold port A idle
//   we         out  1       regfile write enable (registered)
//   waddr      out  ADDR_W  regfile write address (registered)
//   wdata      out  DATA_W  regfile write data (registered)
// BEHAVIOUR
//   Reset: we=0, waddr=0, wdata=0, stall_req=0, queue empty, starve count 0. All flops synchronous.
//   Latency: accepted result appears on we/waddr/wdata exactly 1 cycle after the select cycle.
//   Select per cycle: a_valid -> drive A; else queue non-empty -> drive queue head, pop it;
//     else we=0 (waddr/wdata hold last value).
//   Address 0: writes to r0 (A or B) are dropped, never set we, never occupy a queue slot;
//     B push to r0 is still handshaken (b_ready) and discarded.
//   b_ready = (count < QDEPTH); push occurs when b_valid & b_ready. Push and pop in same cycle
//     allowed; count unchanged. Push at count==QDEPTH impossible (b_ready=0).
//   B bypass: queue empty and a_valid=0 and B push this cycle -> B selected directly, not queued.
//   WAW: a_valid with a_waddr matching any valid queued entry squashes (invalidates) that entry
//     in the same cycle; A is program-order younger. Squashed entries are popped without write.
//   rqN_pend = 1 iff rqN_addr != 0 and matches a valid queued entry or an incoming B push this
//     cycle. Entry on the write port this cycle is not pending (regfile bypass covers it).
//   Starve counter: increments when a_valid & queue non-empty, clears otherwise; saturates.
//   stall_req next = (count_next == QDEPTH) | (starve_next >= STARVE_MAX); dropped when false.
//   Upstream must hold a_valid=0 while stall_req=1; if violated, A still wins (assertion fires).
//   Reset mid-operation flushes queue and any result in flight; no write issued on following cycle.
// STRUCTURE
//   defines.v: RegBus, RegAddrBus, WriteEnable/Disable, ZeroWord, RstEnable; add WbQDepth,
//   WbStarveMax defaults there.
//   One sub-module: wb_pend_queue -- QDEPTH-entry FIFO with per-entry valid bit, squash-by-
//   address input, and two combinational address-match outputs. Arbiter/output regs in top.
// TESTING
//   Reset: rst=1 two cycles with a_valid=1 -> we=0, stall_req=0, b_ready=1 throughout.
//   A only: a_valid, a_waddr=5, a_wdata=32'h1234 at cycle t -> we=1,waddr=5,wdata=32'h1234 at t+1.
//   B bypass + queue: B push r7=32'hAA while A idle -> written t+1; B push r9 while a_valid r3 ->
//     r3 at t+1, r9 at t+2; rq1_addr=9 gives rq1_pend=1 at t and t+1 only.
//   Full/stall: a_valid every cycle, push B to r1,r2 -> b_ready=0, stall_req=1 next cycle;
//     drop a_valid -> r1 then r2 written in order, stall_req clears.
//   WAW squash: queue holds r4=32'h11, then a_valid r4=32'h22 -> only r4=32'h22 written; r0 pushes
//     on either port -> no we pulse.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Widths and queue defaults match the core's register bus definitions.
package wb_write_arbiter_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int WB_Q_DEPTH    = 2;
    localparam int WB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_A,
        SEL_Q,
        SEL_B
    } wb_sel_e;

endpackage

// File: rtl/wb_pend_queue.sv
// Small FIFO of pending port-B writes with per-entry valid bits.
// Entries can be squashed by address and probed by two read ports.
module wb_pend_queue
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS,
    parameter int QDEPTH = WB_Q_DEPTH,
    parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [ADDR_W-1:0] squash_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [ADDR_W-1:0] rq2_addr,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              rq1_hit,
    output logic              rq2_hit
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [QDEPTH-1:0] vld;
    logic [ADDR_W-1:0] addr_q [QDEPTH];
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    assign head_valid = vld[head];
    assign head_addr  = addr_q[head];
    assign head_data  = data_q[head];

    // Squash matching entries, then pop head and append at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (squash_en) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (vld[i] && addr_q[i] == squash_addr) begin
                        vld[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PTR_W'(1);
            end
            if (push) begin
                vld[tail]    <= 1'b1;
                addr_q[tail] <= push_addr;
                data_q[tail] <= push_data;
                tail         <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Address match of both read ports against live entries.
    always_comb begin
        rq1_hit = 1'b0;
        rq2_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (vld[i] && addr_q[i] == rq1_addr) begin
                rq1_hit = 1'b1;
            end
            if (vld[i] && addr_q[i] == rq2_addr) begin
                rq2_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU results win, long-latency
// results queue behind them; pending queued writes are reported to ID.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = REG_BUS,
    parameter int ADDR_W     = REG_ADDR_BUS,
    parameter int QDEPTH     = WB_Q_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [ADDR_W-1:0] rq2_addr,
    output logic              rq1_pend,
    output logic              rq2_pend,
    output logic              stall_req,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  q_count;
    logic              q_head_vld;
    logic [ADDR_W-1:0] q_head_addr;
    logic [DATA_W-1:0] q_head_data;
    logic              q_hit1;
    logic              q_hit2;

    logic              q_nonempty;
    logic              b_push;
    logic              bypass;
    logic              q_push;
    logic              q_pop;

    wb_sel_e           sel;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;

    logic [CNT_W-1:0]  count_next;
    logic [STV_W-1:0]  starve;
    logic [STV_W-1:0]  starve_next;
    logic              stall_next;

    assign q_nonempty = q_count != '0;
    assign b_ready    = q_count < CNT_W'(QDEPTH);
    assign b_push     = b_valid & b_ready;
    assign bypass     = b_push & ~q_nonempty & ~a_valid;
    assign q_push     = b_push & (b_waddr != '0) & ~bypass;
    assign q_pop      = ~a_valid & q_nonempty;

    assign rq1_pend = (rq1_addr != '0)
                    & (q_hit1 | (b_push & (b_waddr == rq1_addr)));
    assign rq2_pend = (rq2_addr != '0)
                    & (q_hit2 | (b_push & (b_waddr == rq2_addr)));

    wb_pend_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (q_push),
        .push_addr   (b_waddr),
        .push_data   (b_wdata),
        .pop         (q_pop),
        .squash_en   (a_valid),
        .squash_addr (a_waddr),
        .rq1_addr    (rq1_addr),
        .rq2_addr    (rq2_addr),
        .count       (q_count),
        .head_valid  (q_head_vld),
        .head_addr   (q_head_addr),
        .head_data   (q_head_data),
        .rq1_hit     (q_hit1),
        .rq2_hit     (q_hit2)
    );

    // Pick this cycle's writer; r0 and squashed entries never write.
    always_comb begin
        sel    = SEL_NONE;
        we_d   = 1'b0;
        addr_d = waddr;
        data_d = wdata;
        unique case (1'b1)
            a_valid: sel = SEL_A;
            q_pop:   sel = SEL_Q;
            bypass:  sel = SEL_B;
            default: sel = SEL_NONE;
        endcase
        case (sel)
            SEL_A: begin
                if (a_waddr != '0) begin
                    we_d   = 1'b1;
                    addr_d = a_waddr;
                    data_d = a_wdata;
                end
            end
            SEL_Q: begin
                if (q_head_vld) begin
                    we_d   = 1'b1;
                    addr_d = q_head_addr;
                    data_d = q_head_data;
                end
            end
            SEL_B: begin
                if (b_waddr != '0) begin
                    we_d   = 1'b1;
                    addr_d = b_waddr;
                    data_d = b_wdata;
                end
            end
            default: ;
        endcase
    end

    // Next occupancy and starvation state driving the stall request.
    always_comb begin
        count_next = q_count + CNT_W'(q_push) - CNT_W'(q_pop);
        starve_next = '0;
        if (a_valid & q_nonempty) begin
            if (starve == STV_W'(STARVE_MAX)) begin
                starve_next = starve;
            end else begin
                starve_next = starve + STV_W'(1);
            end
        end
        stall_next = (count_next == CNT_W'(QDEPTH))
                   | (starve_next >= STV_W'(STARVE_MAX));
    end

    // Registered write port, stall request and starvation count.
    always_ff @(posedge clk) begin
        if (rst) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            stall_req <= 1'b0;
            starve    <= '0;
        end else begin
            we        <= we_d;
            waddr     <= addr_d;
            wdata     <= data_d;
            stall_req <= stall_next;
            starve    <= starve_next;
        end
    end

    a_idle_on_stall: assert property (
        @(posedge clk) disable iff (rst) !(a_valid && stall_req)
    );

endmodule
